// File: rtl/single_cycle_mips_core.sv
// Single-cycle 32-bit MIPS-I subset CPU with Harvard instruction/data memories.
// Optional HI/LO multiply/divide unit enabled by defining MIPS_MULDIV_EN.

module single_cycle_mips_imem #(
    parameter int WORDS = 256
) (
    input  logic [31:0] i_addr,
    output logic [31:0] o_rdata
);
    localparam int AW = $clog2(WORDS);

    logic [31:0] mem_data [0:WORDS-1];
    logic [29:0] w_idx;

    assign w_idx   = i_addr[31:2] % 30'(WORDS);
    assign o_rdata = mem_data[w_idx[AW-1:0]];
endmodule

module single_cycle_mips_dmem #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    localparam int AW = $clog2(WORDS);

    logic [31:0] mem_data [0:WORDS-1];
    logic [29:0] w_idx;

    assign w_idx   = i_addr[31:2] % 30'(WORDS);
    assign o_rdata = mem_data[w_idx[AW-1:0]];

    // Word store; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_data[w_idx[AW-1:0]] <= i_wdata;
        end
    end
endmodule

module single_cycle_mips_core #(
    parameter int          IMEM_WORDS = 256,
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset
);
    logic [31:0] PC;
    logic [31:0] r_regfile [1:31];

    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_jidx;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic [31:0] w_pc4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_mem_addr;
    logic [31:0] w_dmem_rdata;
    logic [31:0] w_next_pc;
    logic        w_rf_we_raw;
    logic        w_rf_we;
    logic [4:0]  w_rf_wa;
    logic [31:0] w_rf_wd;
    logic        w_dmem_we_raw;
    logic        w_dmem_we;

`ifdef MIPS_MULDIV_EN
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        w_hi_we;
    logic        w_lo_we;
    logic [31:0] w_hi_wd;
    logic [31:0] w_lo_wd;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_quot_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;
    logic        w_div_ok;
`endif

    single_cycle_mips_imem #(.WORDS(IMEM_WORDS)) imem (
        .i_addr  (PC),
        .o_rdata (w_instr)
    );

    single_cycle_mips_dmem #(.WORDS(DMEM_WORDS)) dmem (
        .clk     (clk),
        .i_we    (w_dmem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_rt_val),
        .o_rdata (w_dmem_rdata)
    );

    assign w_op       = w_instr[31:26];
    assign w_rs       = w_instr[25:21];
    assign w_rt       = w_instr[20:16];
    assign w_rd       = w_instr[15:11];
    assign w_shamt    = w_instr[10:6];
    assign w_funct    = w_instr[5:0];
    assign w_imm      = w_instr[15:0];
    assign w_jidx     = w_instr[25:0];

    assign w_rs_val   = (w_rs == 5'd0) ? 32'd0 : r_regfile[w_rs];
    assign w_rt_val   = (w_rt == 5'd0) ? 32'd0 : r_regfile[w_rt];
    assign w_sext     = {{16{w_imm[15]}}, w_imm};
    assign w_zext     = {16'd0, w_imm};
    assign w_pc4      = PC + 32'd4;
    assign w_br_tgt   = w_pc4 + (w_sext << 2);
    assign w_j_tgt    = {w_pc4[31:28], w_jidx, 2'b00};
    assign w_mem_addr = w_rs_val + w_sext;

`ifdef MIPS_MULDIV_EN
    // Low 64 bits of the sign-extended product equal the signed product.
    assign w_prod_s = {{32{w_rs_val[31]}}, w_rs_val} * {{32{w_rt_val[31]}}, w_rt_val};
    assign w_prod_u = {32'd0, w_rs_val} * {32'd0, w_rt_val};
    assign w_div_ok = (w_rt_val != 32'd0);
    assign w_quot_s = w_div_ok ? 32'($signed(w_rs_val) / $signed(w_rt_val)) : 32'd0;
    assign w_rem_s  = w_div_ok ? 32'($signed(w_rs_val) % $signed(w_rt_val)) : 32'd0;
    assign w_quot_u = w_div_ok ? (w_rs_val / w_rt_val) : 32'd0;
    assign w_rem_u  = w_div_ok ? (w_rs_val % w_rt_val) : 32'd0;
`endif

    // Instruction decode and execute: next PC, register write-back and store enable.
    always_comb begin
        w_next_pc     = w_pc4;
        w_rf_we_raw   = 1'b0;
        w_rf_wa       = w_rt;
        w_rf_wd       = 32'd0;
        w_dmem_we_raw = 1'b0;
`ifdef MIPS_MULDIV_EN
        w_hi_we       = 1'b0;
        w_lo_we       = 1'b0;
        w_hi_wd       = 32'd0;
        w_lo_wd       = 32'd0;
`endif
        case (w_op)
            6'h00: begin
                w_rf_wa = w_rd;
                case (w_funct)
                    6'h00: begin w_rf_we_raw = 1'b1; w_rf_wd = w_rt_val << w_shamt; end
                    6'h02: begin w_rf_we_raw = 1'b1; w_rf_wd = w_rt_val >> w_shamt; end
                    6'h03: begin w_rf_we_raw = 1'b1; w_rf_wd = 32'($signed(w_rt_val) >>> w_shamt); end
                    6'h04: begin w_rf_we_raw = 1'b1; w_rf_wd = w_rt_val << w_rs_val[4:0]; end
                    6'h06: begin w_rf_we_raw = 1'b1; w_rf_wd = w_rt_val >> w_rs_val[4:0]; end
                    6'h07: begin w_rf_we_raw = 1'b1; w_rf_wd = 32'($signed(w_rt_val) >>> w_rs_val[4:0]); end
                    6'h08: w_next_pc = w_rs_val;
                    6'h20, 6'h21: begin w_rf_we_raw = 1'b1; w_rf_wd = w_rs_val + w_rt_val; end
                    6'h22, 6'h23: begin w_rf_we_raw = 1'b1; w_rf_wd = w_rs_val - w_rt_val; end
                    6'h24: begin w_rf_we_raw = 1'b1; w_rf_wd = w_rs_val & w_rt_val; end
                    6'h25: begin w_rf_we_raw = 1'b1; w_rf_wd = w_rs_val | w_rt_val; end
                    6'h26: begin w_rf_we_raw = 1'b1; w_rf_wd = w_rs_val ^ w_rt_val; end
                    6'h27: begin w_rf_we_raw = 1'b1; w_rf_wd = ~(w_rs_val | w_rt_val); end
                    6'h2a: begin w_rf_we_raw = 1'b1; w_rf_wd = {31'd0, $signed(w_rs_val) < $signed(w_rt_val)}; end
                    6'h2b: begin w_rf_we_raw = 1'b1; w_rf_wd = {31'd0, w_rs_val < w_rt_val}; end
`ifdef MIPS_MULDIV_EN
                    6'h10: begin w_rf_we_raw = 1'b1; w_rf_wd = r_hi; end
                    6'h11: begin w_hi_we = 1'b1; w_hi_wd = w_rs_val; end
                    6'h12: begin w_rf_we_raw = 1'b1; w_rf_wd = r_lo; end
                    6'h13: begin w_lo_we = 1'b1; w_lo_wd = w_rs_val; end
                    6'h18: begin
                        w_hi_we = 1'b1; w_lo_we = 1'b1;
                        w_hi_wd = w_prod_s[63:32]; w_lo_wd = w_prod_s[31:0];
                    end
                    6'h19: begin
                        w_hi_we = 1'b1; w_lo_we = 1'b1;
                        w_hi_wd = w_prod_u[63:32]; w_lo_wd = w_prod_u[31:0];
                    end
                    6'h1a: begin
                        w_hi_we = w_div_ok; w_lo_we = w_div_ok;
                        w_hi_wd = w_rem_s;  w_lo_wd = w_quot_s;
                    end
                    6'h1b: begin
                        w_hi_we = w_div_ok; w_lo_we = w_div_ok;
                        w_hi_wd = w_rem_u;  w_lo_wd = w_quot_u;
                    end
`endif
                    default: w_rf_we_raw = 1'b0;
                endcase
            end
            6'h02: w_next_pc = w_j_tgt;
            6'h03: begin
                w_next_pc   = w_j_tgt;
                w_rf_we_raw = 1'b1;
                w_rf_wa     = 5'd31;
                w_rf_wd     = w_pc4;
            end
            6'h04: w_next_pc = (w_rs_val == w_rt_val) ? w_br_tgt : w_pc4;
            6'h05: w_next_pc = (w_rs_val != w_rt_val) ? w_br_tgt : w_pc4;
            6'h08, 6'h09: begin w_rf_we_raw = 1'b1; w_rf_wd = w_rs_val + w_sext; end
            6'h0a: begin w_rf_we_raw = 1'b1; w_rf_wd = {31'd0, $signed(w_rs_val) < $signed(w_sext)}; end
            6'h0b: begin w_rf_we_raw = 1'b1; w_rf_wd = {31'd0, w_rs_val < w_sext}; end
            6'h0c: begin w_rf_we_raw = 1'b1; w_rf_wd = w_rs_val & w_zext; end
            6'h0d: begin w_rf_we_raw = 1'b1; w_rf_wd = w_rs_val | w_zext; end
            6'h0e: begin w_rf_we_raw = 1'b1; w_rf_wd = w_rs_val ^ w_zext; end
            6'h0f: begin w_rf_we_raw = 1'b1; w_rf_wd = {w_imm, 16'd0}; end
            6'h23: begin w_rf_we_raw = 1'b1; w_rf_wd = w_dmem_rdata; end
            6'h2b: w_dmem_we_raw = 1'b1;
            default: w_rf_we_raw = 1'b0;
        endcase
    end

    assign w_rf_we   = w_rf_we_raw && (w_rf_wa != 5'd0);
    // Gating with reset drops a store coinciding with reset assertion.
    assign w_dmem_we = w_dmem_we_raw && reset;

    // PC and register file update; reset clears both asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC <= RESET_PC;
            for (int i = 1; i < 32; i++) begin
                r_regfile[i] <= 32'd0;
            end
        end else begin
            PC <= w_next_pc;
            if (w_rf_we) begin
                r_regfile[w_rf_wa] <= w_rf_wd;
            end
        end
    end

`ifdef MIPS_MULDIV_EN
    // HI/LO update from multiply, divide and move-to instructions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else begin
            if (w_hi_we) begin
                r_hi <= w_hi_wd;
            end
            if (w_lo_we) begin
                r_lo <= w_lo_wd;
            end
        end
    end
`endif
endmodule

// File: tb/tb_single_cycle_mips_core.sv
// Directed program test of single_cycle_mips_core with a queue-based scoreboard.
module tb_single_cycle_mips_core;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    single_cycle_mips_core #(
        .IMEM_WORDS (256),
        .DMEM_WORDS (256),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [5:0] funct, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    task automatic push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        sb_item_t it;
        n_assert++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_underflow: observed %h with no expected entry", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic load_program();
        logic [31:0] prog [0:40];
        prog[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        prog[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        prog[2]  = enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0);
        prog[3]  = enc_i(6'h2b, 5'd0, 5'd3, 16'd200);
        prog[4]  = enc_i(6'h0f, 5'd0, 5'd4, 16'h1234);
        prog[5]  = enc_i(6'h0d, 5'd4, 5'd4, 16'h5678);
        prog[6]  = enc_i(6'h2b, 5'd0, 5'd4, 16'd204);
        prog[7]  = enc_i(6'h23, 5'd0, 5'd5, 16'd204);
        prog[8]  = enc_i(6'h2b, 5'd0, 5'd5, 16'd208);
        prog[9]  = enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF);
        prog[10] = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
        prog[11] = enc_r(6'h2a, 5'd1, 5'd2, 5'd6, 5'd0);
        prog[12] = enc_r(6'h2b, 5'd1, 5'd2, 5'd7, 5'd0);
        prog[13] = enc_i(6'h2b, 5'd0, 5'd6, 16'd212);
        prog[14] = enc_i(6'h2b, 5'd0, 5'd7, 16'd216);
        prog[15] = enc_i(6'h0f, 5'd0, 5'd8, 16'h8000);
        prog[16] = enc_r(6'h03, 5'd0, 5'd8, 5'd9, 5'd4);
        prog[17] = enc_i(6'h2b, 5'd0, 5'd9, 16'd220);
        prog[18] = enc_i(6'h04, 5'd0, 5'd0, 16'd1);
        prog[19] = enc_i(6'h08, 5'd0, 5'd10, 16'h0077);
        prog[20] = enc_i(6'h2b, 5'd0, 5'd10, 16'd224);
        prog[21] = enc_i(6'h05, 5'd0, 5'd0, 16'd1);
        prog[22] = enc_i(6'h08, 5'd0, 5'd11, 16'h0055);
        prog[23] = enc_i(6'h2b, 5'd0, 5'd11, 16'd228);
        prog[24] = enc_j(6'h03, 26'd36);
        prog[25] = enc_i(6'h2b, 5'd0, 5'd12, 16'd232);
        prog[26] = enc_i(6'h2b, 5'd0, 5'd31, 16'd236);
        prog[27] = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
        prog[28] = enc_i(6'h2b, 5'd0, 5'd0, 16'd240);
        prog[29] = enc_i(6'h08, 5'd0, 5'd13, 16'hFFF0);
        prog[30] = enc_r(6'h02, 5'd0, 5'd13, 5'd14, 5'd4);
        prog[31] = enc_i(6'h2b, 5'd0, 5'd14, 16'd244);
        prog[32] = enc_r(6'h27, 5'd0, 5'd0, 5'd15, 5'd0);
        prog[33] = enc_i(6'h2b, 5'd0, 5'd15, 16'd248);
        prog[34] = 32'hFC22_0000;
        prog[35] = enc_j(6'h02, 26'd40);
        prog[36] = enc_i(6'h08, 5'd0, 5'd12, 16'h0123);
        prog[37] = enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0);
        prog[38] = 32'd0;
        prog[39] = 32'd0;
        prog[40] = enc_j(6'h02, 26'd40);
        for (int i = 0; i < 256; i++) begin
            dut.imem.mem_data[i] = 32'd0;
        end
        for (int i = 0; i <= 40; i++) begin
            dut.imem.mem_data[i] = prog[i];
        end
    endtask

    initial begin
        logic [31:0] golden [50:62];
        logic        halted;
        golden[50] = 32'h0000_0002; golden[51] = 32'h1234_5678; golden[52] = 32'h1234_5678;
        golden[53] = 32'h0000_0001; golden[54] = 32'h0000_0000; golden[55] = 32'hF800_0000;
        golden[56] = 32'h0000_0000; golden[57] = 32'h0000_0055; golden[58] = 32'h0000_0123;
        golden[59] = 32'h0000_0064; golden[60] = 32'h0000_0000; golden[61] = 32'h0FFF_FFFF;
        golden[62] = 32'hFFFF_FFFF;

        load_program();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        push("pc_reset", 32'h0);
        pop_check(dut.PC);
        for (int i = 1; i < 32; i++) begin
            push($sformatf("reg_reset_%0d", i), 32'h0);
            pop_check(dut.r_regfile[i]);
        end

        // Straight-line fetch sequence after release.
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("pc_step_%0d", k), 32'(4 * k));
            @(posedge clk);
            #1;
            pop_check(dut.PC);
        end

        halted = 1'b0;
        for (int c = 0; c < 300 && !halted; c++) begin
            @(posedge clk);
            #1;
            if (dut.PC == 32'h0000_00A0) halted = 1'b1;
        end
        push("halt_reached", 32'h1);
        pop_check({31'd0, halted});

        for (int w = 50; w <= 62; w++) begin
            push($sformatf("dmem_%0d", w), golden[w]);
            pop_check(dut.dmem.mem_data[w]);
        end
        push("reg1_final", 32'hFFFF_FFFF);
        pop_check(dut.r_regfile[1]);
        push("reg2_unrecognised_nop", 32'h0000_0001);
        pop_check(dut.r_regfile[2]);
        push("reg31_link", 32'h0000_0064);
        pop_check(dut.r_regfile[31]);

        // Asynchronous reset mid-run: PC and registers clear without a clock edge.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        push("pc_async_reset", 32'h0);
        pop_check(dut.PC);
        push("reg1_async_reset", 32'h0);
        pop_check(dut.r_regfile[1]);
        push("reg31_async_reset", 32'h0);
        pop_check(dut.r_regfile[31]);

        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        push("pc_rerun_0", 32'h0);
        pop_check(dut.PC);
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("pc_rerun_%0d", k), 32'(4 * k));
            @(posedge clk);
            #1;
            pop_check(dut.PC);
        end
        push("reg3_rerun", 32'h0000_0002);
        pop_check(dut.r_regfile[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
